uart_fifo_tx: RTL and testbench
===============================

UART_FIFO_TX -- requirements
Module: uart_fifo_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, the clk cycles per serial bit (50 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port tx_en  input  1  high permits starting new frames.
REQ-005 SHALL have port fifo_empty  input  1  buffer-empty flag from the byte FIFO.
REQ-006 SHALL have port fifo_data  input  8  byte FIFO registered output, valid the cycle after a read strobe.
REQ-007 SHALL have port fifo_rd_en  output  1  one-cycle read strobe to the byte FIFO.
REQ-008 SHALL have port tx  output  1  serial line, idle high.
REQ-009 SHALL have port busy  output  1  high while a byte is being fetched or sent.
REQ-010 SHALL have port tx_done  output  1  one-cycle pulse at frame end.

Function
REQ-011 SHALL implement states IDLE, READ, LOAD, START, DATA, PARITY (parity build only), STOP.
REQ-012 IDLE: when tx_en=1 and fifo_empty=0, SHALL go to READ; otherwise SHALL stay in IDLE.
REQ-013 READ: fifo_rd_en SHALL be 1 for exactly this one cycle; next state LOAD; fifo_empty SHALL be ignored.
REQ-014 LOAD: SHALL capture fifo_data into the shift register at the end of this cycle; next state START.
REQ-015 fifo_rd_en SHALL be registered and SHALL pulse at most once per frame; it SHALL never be 1 outside READ.
REQ-016 START, DATA bits, PARITY and STOP SHALL each hold tx for exactly CLKS_PER_BIT cycles, timed by a bit counter counting 0..CLKS_PER_BIT-1.
REQ-017 tx SHALL be registered: 0 in START, data LSB first in DATA (8 bits, 3-bit index), 1 in STOP, 1 in IDLE/READ/LOAD.
REQ-018 tx SHALL fall exactly 2 cycles after the rising edge of fifo_rd_en.
REQ-019 tx_done SHALL be 1 in the last cycle of STOP only.
REQ-020 After STOP, when tx_en=1 and fifo_empty=0, SHALL go directly to READ (inter-frame idle high = 2 cycles); otherwise SHALL go to IDLE.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 tx_en going low mid-frame SHALL NOT abort the frame; it SHALL only block the next READ.
REQ-023 Changes on fifo_data outside LOAD SHALL NOT affect the frame in progress.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, tx=1, fifo_rd_en=0, busy=0, tx_done=0, and bit counter, bit index and shift register to 0.
REQ-025 Reset mid-frame SHALL drop the frame in progress (the byte is lost); after release, the first READ SHALL occur no earlier than the second rising edge.

Configuration
REQ-026 Macro UART_TX_PARITY_EN defined: SHALL insert PARITY after DATA, with tx = XOR of the 8 data bits (even parity), and the frame SHALL be 11*CLKS_PER_BIT cycles.
REQ-027 Macro UART_TX_PARITY_EN undefined: PARITY state and logic SHALL be absent, DATA SHALL go directly to STOP, and the frame SHALL be 10*CLKS_PER_BIT cycles (8N1).

Verification
REQ-028 CLKS_PER_BIT=4, no parity, one byte 0x55 -> one fifo_rd_en pulse; tx = 0,1,0,1,0,1,0,1,0,1, each 4 cycles; tx_done once at cycle 40 after the tx fall.
REQ-029 Parity build, bytes 0xA5 then 0x01 -> parity bits 0 then 1; each frame 44 cycles; tx high for exactly 2 cycles between frames.
REQ-030 FIFO holding 3 bytes, tx_en=1 -> exactly 3 fifo_rd_en pulses, 3 frames back-to-back, then busy=0 and tx=1 with fifo_empty=1.
REQ-031 tx_en dropped during DATA bit 3 with bytes pending -> current frame completes; no fifo_rd_en until tx_en returns high.
REQ-032 rst_n low during DATA -> tx=1 and busy=0 the same cycle with no clock edge needed; after release with fifo_empty=0 and tx_en=1, a new READ follows and the full frame is correct.
REQ-033 fifo_data toggled every cycle after LOAD -> transmitted bits match the byte captured in LOAD.

Source files
------------

// File: rtl/uart_fifo_tx.sv
// ============================================================================
// Module      : uart_fifo_tx
// Description : UART transmitter that pulls bytes from a registered-output FIFO
//               and sends 8N1 frames (8E1 when UART_TX_PARITY_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_fifo_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam logic [15:0] c_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd5,
`endif
        STOP   = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_next;
    logic [2:0]  r_idx;
    logic [2:0]  w_idx_next;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_next;
    logic        r_armed;
    logic        r_tx;
    logic        w_tx_next;
    logic        r_rd_en;
    logic        r_busy;
    logic        r_done;
    logic        w_bit_last;

    assign w_bit_last = (r_cnt == c_LAST);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        case (r_state)
            IDLE: begin
                // r_armed holds off the first fetch by one edge after reset release
                if (r_armed && tx_en && !fifo_empty) begin
                    w_state_next = READ;
                end
            end
            READ: begin
                w_state_next = LOAD;
            end
            LOAD: begin
                w_shift_next = fifo_data;
                w_cnt_next   = 16'd0;
                w_state_next = START;
            end
            START: begin
                if (w_bit_last) begin
                    w_cnt_next   = 16'd0;
                    w_idx_next   = 3'd0;
                    w_state_next = DATA;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            DATA: begin
                if (w_bit_last) begin
                    w_cnt_next = 16'd0;
                    if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end else begin
                        w_idx_next = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_bit_last) begin
                    w_cnt_next   = 16'd0;
                    w_state_next = STOP;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
`endif
            STOP: begin
                if (w_bit_last) begin
                    w_cnt_next = 16'd0;
                    if (tx_en && !fifo_empty) begin
                        w_state_next = READ;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state view so they align with the state
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[w_idx_next];
`ifdef UART_TX_PARITY_EN
            PARITY:  w_tx_next = ^w_shift_next;
`endif
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 16'd0;
            r_idx   <= 3'd0;
            r_shift <= 8'd0;
            r_armed <= 1'b0;
            r_tx    <= 1'b1;
            r_rd_en <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
            r_armed <= 1'b1;
            r_tx    <= w_tx_next;
            r_rd_en <= (w_state_next == READ);
            r_busy  <= (w_state_next != IDLE);
            r_done  <= (w_state_next == STOP) && (w_cnt_next == c_LAST);
        end
    end

    assign tx         = r_tx;
    assign fifo_rd_en = r_rd_en;
    assign busy       = r_busy;
    assign tx_done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_fifo_tx.sv
// ============================================================================
// Module      : tb_uart_fifo_tx
// Description : Directed self-checking bench for uart_fifo_tx (CLKS_PER_BIT=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_fifo_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int SLOTS = 11;
`else
    localparam int SLOTS = 10;
`endif
    localparam int FR = SLOTS * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_en = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [16];
    int         wp = 0;
    int         rp = 0;
    logic       toggle = 1'b0;

    uart_fifo_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_en      (tx_en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    // Byte FIFO model with registered read data
    assign fifo_empty = (wp == rp);
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_data <= mem[rp[3:0]];
            rp        <= rp + 1;
        end else if (toggle) begin
            fifo_data <= ~fifo_data;
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wp[3:0]] = b;
        wp = wp + 1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic slot_val(input logic [7:0] b, input int s);
        if (s == 0) return 1'b0;
        if (s <= 8) return b[s-1];
`ifdef UART_TX_PARITY_EN
        if (s == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Waits for the read strobe, then checks latency, every bit slot and tx_done
    task automatic do_frame(input logic [7:0] b, input int drop_at, output int waited);
        logic v [1:44];
        int   dn;
        int   last_done;
        int   rdc;
        int   bz;
        logic [3:0] obs;
        waited = 0;
        do begin
            @(negedge clk);
            waited = waited + 1;
        end while (fifo_rd_en !== 1'b1 && waited < 200);
        check("rd_pulse", fifo_rd_en, 1);
        @(negedge clk);
        check("rd_one_cycle", fifo_rd_en, 0);
        check("tx_high_load", tx, 1);
        @(negedge clk);
        check("tx_fall_2cyc", tx, 0);
        v[1] = tx;
        dn = tx_done ? 1 : 0;
        last_done = tx_done ? 1 : 0;
        rdc = 0;
        bz = busy ? 0 : 1;
        for (int n = 2; n <= FR; n++) begin
            @(negedge clk);
            if (n == drop_at) tx_en = 1'b0;
            v[n] = tx;
            if (tx_done) begin
                dn = dn + 1;
                last_done = n;
            end
            if (fifo_rd_en) rdc = rdc + 1;
            if (!busy) bz = bz + 1;
        end
        for (int s = 0; s < SLOTS; s++) begin
            obs = {v[4*s+1], v[4*s+2], v[4*s+3], v[4*s+4]};
            check($sformatf("slot%0d_byte%02h", s, b), obs, {4{slot_val(b, s)}});
        end
        check("done_count", dn, 1);
        check("done_pos", last_done, FR);
        check("rd_in_frame", rdc, 0);
        check("busy_low_in_frame", bz, 0);
    endtask

    initial begin
        int w;
        int rdc;
        int bh;

        // Reset state with a byte already pending
        push(8'h55);
        tx_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_done", tx_done, 0);
        rst_n = 1'b1;

        // 0x55 single frame; first READ on the second edge after release
        do_frame(8'h55, 0, w);
        check("release_wait", w, 2);
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_tx", tx, 1);

        // Three bytes back-to-back
        push(8'h3C);
        push(8'hA5);
        push(8'h01);
        do_frame(8'h3C, 0, w);
        check("b2b_first_wait", w, 1);
        do_frame(8'hA5, 0, w);
        check("b2b_gap", w, 1);
        do_frame(8'h01, 0, w);
        check("b2b_gap2", w, 1);
        @(negedge clk);
        check("drain_busy", busy, 0);
        check("drain_tx", tx, 1);
        check("drain_empty", fifo_empty, 1);
        @(negedge clk);
        check("drain_rd_en", fifo_rd_en, 0);

        // tx_en dropped in DATA bit 3: frame completes, no further fetch
        push(8'hC3);
        push(8'h7E);
        do_frame(8'hC3, 18, w);
        rdc = 0;
        bh = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fifo_rd_en) rdc = rdc + 1;
            if (busy) bh = bh + 1;
        end
        check("hold_no_rd", rdc, 0);
        check("hold_not_busy", bh, 0);
        tx_en = 1'b1;
        do_frame(8'h7E, 0, w);
        check("resume_wait", w, 1);

        // Asynchronous reset during DATA drops the frame
        push(8'h96);
        push(8'h5A);
        w = 0;
        do begin
            @(negedge clk);
            w = w + 1;
        end while (fifo_rd_en !== 1'b1 && w < 200);
        check("rst_case_rd", fifo_rd_en, 1);
        repeat (14) @(negedge clk);
        check("rst_case_in_data", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tx", tx, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", tx_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_frame(8'h5A, 0, w);
        check("rst_release_wait", w, 2);

        // fifo_data churning after LOAD must not corrupt the frame
        toggle = 1'b1;
        push(8'hE4);
        do_frame(8'hE4, 0, w);
        toggle = 1'b0;
        @(negedge clk);
        check("final_busy", busy, 0);
        check("final_tx", tx, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
